systolic_pq_sched: RTL

//  Shares the single insert/extract port of the systolic priority queue among NREQ requesters.

---
 rtl/systolic_pq_pkg.sv | 21 ++
 rtl/systolic_pq_sched_rr_arbiter.sv | 37 +++
 rtl/systolic_pq_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/systolic_pq_pkg.sv
// Shared types and constants for the systolic priority-queue scheduler.
// Word layout is {key, value}; all-ones is the "empty" sentinel.
package systolic_pq_pkg;

    localparam int KW = 8;
    localparam int VW = 4;
    localparam int DW = KW + VW;

    typedef logic [DW-1:0] pq_word_t;

    localparam pq_word_t PQINF    = '1;
    localparam pq_word_t PQNEGINF = '0;

    typedef enum logic [1:0] {
        IDLE,
        INS,
        EXT,
        RSP
    } sched_state_t;

endpackage

// File: rtl/systolic_pq_sched_rr_arbiter.sv
// Round-robin arbiter: first eligible requester at or after the pointer.
// Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter
    import systolic_pq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_elig,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int IW = $clog2(N);

    int w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!o_any && i_elig[w_j]) begin
                o_any      = 1'b1;
                o_idx      = IW'(w_j);
                o_gnt[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_pq_sched.sv
// Shares the node-0 insert/extract port of a systolic priority queue
// among NREQ requesters, aligning every op to the queue's even phase.
module systolic_pq_sched
    import systolic_pq_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int CAPACITY = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_op,
    input  logic [NREQ*DW-1:0]            req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic                          rsp_valid,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output pq_word_t                      rsp_data,
    output logic                          rsp_empty,
    input  logic                          rsp_ready,
    input  logic                          pq_even,
    output logic                          pq_ivalid,
    output pq_word_t                      pq_idata,
    input  logic                          pq_irdy,
    output logic                          pq_ovalid,
    input  logic                          pq_ordy,
    input  pq_word_t                      pq_min,
    output logic [$clog2(CAPACITY+1)-1:0] count,
    output logic                          full,
    output logic                          empty
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(CAPACITY + 1);

    sched_state_t   r_state;
    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  r_id;
    pq_word_t       r_data;
    pq_word_t       r_rsp_data;
    logic           r_rsp_empty;
    logic [CW-1:0]  r_count;

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_gnt_idx;
    logic            w_any;
    logic            w_grant;
    logic            w_empty_ext;
    logic            w_ins_acc;
    logic            w_ext_acc;

    assign full  = (r_count == CW'(CAPACITY));
    assign empty = (r_count == '0);
    assign count = r_count;

    // Inserts are held back while full; extracts always compete.
    assign w_elig = req_valid & ~(~req_op & {NREQ{full}});

    rr_arbiter #(.N(NREQ)) u_arb (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt),
        .o_idx  (w_gnt_idx),
        .o_any  (w_any)
    );

    assign w_grant     = (r_state == IDLE) && !pq_even && w_any;
    assign w_empty_ext = w_grant && req_op[w_gnt_idx] && empty;
    assign w_ins_acc   = (r_state == INS) && pq_even && pq_irdy;
    assign w_ext_acc   = (r_state == EXT) && pq_even && pq_ordy;

    assign pq_ivalid = (r_state == INS) && pq_even;
    assign pq_ovalid = (r_state == EXT) && pq_even;
    assign pq_idata  = r_data;
    assign rsp_valid = (r_state == RSP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_empty = r_rsp_empty;

    always_comb begin
        req_ready = '0;
        if (w_ins_acc || w_ext_acc) begin
            req_ready[r_id] = 1'b1;
        end else if (w_empty_ext) begin
            req_ready = w_gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_data      <= '0;
            r_rsp_data  <= PQINF;
            r_rsp_empty <= 1'b0;
            r_count     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_ptr  <= (w_gnt_idx == IW'(NREQ - 1)) ? '0
                                  : w_gnt_idx + 1'b1;
                        r_id   <= w_gnt_idx;
                        r_data <= req_data[w_gnt_idx*DW +: DW];
                        if (!req_op[w_gnt_idx]) begin
                            r_state <= INS;
                        end else if (!empty) begin
                            r_state <= EXT;
                        end else begin
                            r_state     <= RSP;
                            r_rsp_data  <= PQINF;
                            r_rsp_empty <= 1'b1;
                        end
                    end
                end
                INS: begin
                    if (w_ins_acc) begin
                        r_count <= r_count + 1'b1;
                        r_state <= IDLE;
                    end
                end
                EXT: begin
                    if (w_ext_acc) begin
                        r_count     <= r_count - 1'b1;
                        r_rsp_data  <= pq_min;
                        r_rsp_empty <= 1'b0;
                        r_state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
